// File: rtl/interlaken_test_sequencer.sv
// Per-core run sequencer for an Interlaken example design: reset, lock, align,
// then NUM_ROUNDS send/receive rounds with per-stage timeouts and latency capture.
module interlaken_test_sequencer #(
  parameter int NUM_ROUNDS     = 2,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_W      = 20,
  parameter int LAT_W          = 16,
  parameter int PM_TICK_PERIOD = 0
) (
  input  logic             init_clk,
  input  logic             clk_reset_n,
  input  logic             rx_gt_locked,
  input  logic             rx_aligned,
  input  logic             tx_done,
  input  logic             rx_done,
  input  logic             tx_busy,
  input  logic             rx_busy,
  input  logic             rx_failed,
  output logic             sys_reset,
  output logic             lbus_tx_rx_restart_in,
  output logic             s_axi_pm_tick,
  output logic [3:0]       state,
  output logic [3:0]       round_cnt,
  output logic [LAT_W-1:0] latency_cycles,
  output logic             latency_valid,
  output logic             test_done,
  output logic             test_pass,
  output logic [2:0]       fail_code
);

  typedef enum logic [3:0] {
    RESET_HOLD      = 4'd0,
    GT_LOCK_WAIT    = 4'd1,
    RX_ALIGN_WAIT   = 4'd2,
    PACKET_SEND     = 4'd3,
    PACKET_RECEIVE  = 4'd4,
    RESTART_WAIT    = 4'd5,
    TX_RX_RESTART   = 4'd6,
    BUSY_WAIT       = 4'd7,
    DONE_WAIT       = 4'd8,
    DONE            = 4'd9,
    FAIL            = 4'd10
  } state_t;

  localparam int               RST_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [3:0]       ROUND_LAST  = 4'(NUM_ROUNDS);

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           w_fail_next;
  logic [RST_W-1:0]     r_rst_cnt;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic [LAT_W-1:0]     r_latency;
  logic                 r_lat_valid;
  logic [3:0]           r_round;
  logic [2:0]           r_fail_code;
  logic                 w_to_expired;
  logic                 w_to_active;
  logic                 w_rx_fail_armed;
  logic                 w_rx_exit;
  logic                 w_both_idle;

  assign w_to_expired    = &r_to_cnt;
  assign w_both_idle     = !tx_busy && !rx_busy;
  assign w_rx_fail_armed = (r_state >= RX_ALIGN_WAIT) && (r_state <= DONE_WAIT);
  assign w_to_active     = (r_state != RESET_HOLD) && (r_state != TX_RX_RESTART) &&
                           (r_state != DONE) && (r_state != FAIL);
  assign w_rx_exit       = (r_state == PACKET_RECEIVE) && rx_done && !rx_failed;

  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n) r_state <= RESET_HOLD;
    else              r_state <= w_next;
  end

  // Advance beats timeout within each state; rx_failed then overrides both.
  always_comb begin
    w_next      = r_state;
    w_fail_next = 3'd0;
    case (r_state)
      RESET_HOLD:     if (r_rst_cnt == RST_LAST) w_next = GT_LOCK_WAIT;
      GT_LOCK_WAIT:   if (rx_gt_locked) w_next = RX_ALIGN_WAIT;
                      else if (w_to_expired) begin w_next = FAIL; w_fail_next = 3'd1; end
      RX_ALIGN_WAIT:  if (rx_aligned) w_next = PACKET_SEND;
                      else if (w_to_expired) begin w_next = FAIL; w_fail_next = 3'd2; end
      PACKET_SEND:    if (tx_done) w_next = PACKET_RECEIVE;
                      else if (w_to_expired) begin w_next = FAIL; w_fail_next = 3'd3; end
      PACKET_RECEIVE: if (rx_done) w_next = ((r_round + 4'd1) == ROUND_LAST) ? DONE_WAIT : RESTART_WAIT;
                      else if (w_to_expired) begin w_next = FAIL; w_fail_next = 3'd4; end
      RESTART_WAIT:   if (w_both_idle) w_next = TX_RX_RESTART;
                      else if (w_to_expired) begin w_next = FAIL; w_fail_next = 3'd5; end
      TX_RX_RESTART:  w_next = BUSY_WAIT;
      BUSY_WAIT:      if (tx_busy && rx_busy) w_next = PACKET_SEND;
                      else if (w_to_expired) begin w_next = FAIL; w_fail_next = 3'd5; end
      DONE_WAIT:      if (w_both_idle) w_next = DONE;
                      else if (w_to_expired) begin w_next = FAIL; w_fail_next = 3'd5; end
      DONE:           w_next = DONE;
      FAIL:           w_next = FAIL;
      default:        w_next = FAIL;
    endcase
    if (w_rx_fail_armed && rx_failed) begin
      w_next      = FAIL;
      w_fail_next = 3'd6;
    end
  end

  always_comb begin
    state                 = r_state;
    sys_reset             = (r_state == RESET_HOLD);
    lbus_tx_rx_restart_in = (r_state == TX_RX_RESTART);
    test_done             = (r_state == DONE) || (r_state == FAIL);
    test_pass             = (r_state == DONE);
  end

  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n)               r_rst_cnt <= '0;
    else if (r_state == RESET_HOLD) r_rst_cnt <= r_rst_cnt + RST_W'(1);
  end

  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n)           r_to_cnt <= '0;
    else if (w_next != r_state) r_to_cnt <= '0;
    else if (w_to_active)       r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
  end

  // Loading 1 on entry makes the first SEND cycle count as one cycle of latency.
  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n)
      r_lat_cnt <= '0;
    else if ((w_next == PACKET_SEND) && (r_state != PACKET_SEND))
      r_lat_cnt <= LAT_W'(1);
    else if (((r_state == PACKET_SEND) || (r_state == PACKET_RECEIVE)) && !(&r_lat_cnt))
      r_lat_cnt <= r_lat_cnt + LAT_W'(1);
  end

  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      r_latency   <= '0;
      r_lat_valid <= 1'b0;
      r_round     <= '0;
    end else begin
      r_lat_valid <= w_rx_exit;
      if (w_rx_exit) begin
        r_latency <= r_lat_cnt;
        r_round   <= r_round + 4'd1;
      end
    end
  end

  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n)                             r_fail_code <= '0;
    else if ((w_next == FAIL) && (r_state != FAIL)) r_fail_code <= w_fail_next;
  end

  assign latency_cycles = r_latency;
  assign latency_valid  = r_lat_valid;
  assign round_cnt      = r_round;
  assign fail_code      = r_fail_code;

  generate
    if (PM_TICK_PERIOD > 0) begin : g_pm
      localparam int PM_W = (PM_TICK_PERIOD > 1) ? $clog2(PM_TICK_PERIOD) : 1;
      localparam logic [PM_W-1:0] PM_LAST = PM_W'(PM_TICK_PERIOD - 1);
      logic [PM_W-1:0] r_pm_cnt;
      logic            w_pm_wrap;

      assign w_pm_wrap = (r_pm_cnt == PM_LAST);

      always_ff @(posedge init_clk or negedge clk_reset_n) begin
        if (!clk_reset_n)   r_pm_cnt <= '0;
        else if (sys_reset) r_pm_cnt <= '0;
        else if (w_pm_wrap) r_pm_cnt <= '0;
        else                r_pm_cnt <= r_pm_cnt + PM_W'(1);
      end

      assign s_axi_pm_tick = w_pm_wrap && !sys_reset;
    end else begin : g_no_pm
      assign s_axi_pm_tick = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_interlaken_test_sequencer.sv
// Scenario bench for interlaken_test_sequencer with a scripted exdes model and a
// latency scoreboard fed at rx_done and drained on latency_valid.
module tb_interlaken_test_sequencer;

  localparam int LAT_W = 16;

  logic             init_clk = 1'b0;
  logic             clk_reset_n = 1'b0;
  logic             rx_gt_locked = 1'b0;
  logic             rx_aligned = 1'b0;
  logic             tx_done = 1'b0;
  logic             rx_done = 1'b0;
  logic             tx_busy = 1'b0;
  logic             rx_busy = 1'b0;
  logic             rx_failed = 1'b0;
  logic             sys_reset;
  logic             lbus_tx_rx_restart_in;
  logic             s_axi_pm_tick;
  logic [3:0]       state;
  logic [3:0]       round_cnt;
  logic [LAT_W-1:0] latency_cycles;
  logic             latency_valid;
  logic             test_done;
  logic             test_pass;
  logic [2:0]       fail_code;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_lat[$];
  int lat_pulses = 0;
  int restart_pulses = 0;
  int mon_exp;
  logic prev_valid = 1'b0;
  logic prev_restart = 1'b0;

  interlaken_test_sequencer #(
    .NUM_ROUNDS(2), .RST_CYCLES(16), .TIMEOUT_W(8), .LAT_W(LAT_W), .PM_TICK_PERIOD(100)
  ) dut (
    .init_clk(init_clk), .clk_reset_n(clk_reset_n),
    .rx_gt_locked(rx_gt_locked), .rx_aligned(rx_aligned),
    .tx_done(tx_done), .rx_done(rx_done), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .rx_failed(rx_failed), .sys_reset(sys_reset),
    .lbus_tx_rx_restart_in(lbus_tx_rx_restart_in), .s_axi_pm_tick(s_axi_pm_tick),
    .state(state), .round_cnt(round_cnt), .latency_cycles(latency_cycles),
    .latency_valid(latency_valid), .test_done(test_done), .test_pass(test_pass),
    .fail_code(fail_code)
  );

  always #5 init_clk = ~init_clk;

  // Drains the latency scoreboard and watches pulse widths of the one-cycle outputs.
  always @(negedge init_clk) begin
    if (latency_valid) begin
      lat_pulses++;
      checks++;
      if (exp_lat.size() == 0) begin
        errors++;
        $display("[TB] FAIL latency_scoreboard: unexpected latency_valid, latency_cycles=%0d", latency_cycles);
      end else begin
        mon_exp = exp_lat.pop_front();
        if (int'(latency_cycles) !== mon_exp) begin
          errors++;
          $display("[TB] FAIL latency_value: got %0d, expected %0d", latency_cycles, mon_exp);
        end
      end
      checks++;
      if (prev_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL latency_valid_width: high on consecutive cycles, expected 1-cycle pulse");
      end
    end
    if (lbus_tx_rx_restart_in) begin
      if (!prev_restart) restart_pulses++;
      checks++;
      if (prev_restart !== 1'b0) begin
        errors++;
        $display("[TB] FAIL restart_width: high on consecutive cycles, expected 1-cycle pulse");
      end
    end
    prev_valid   = latency_valid;
    prev_restart = lbus_tx_rx_restart_in;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge init_clk);
    cyc++;
  endtask

  task automatic clear_inputs();
    rx_gt_locked = 1'b0; rx_aligned = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
    tx_busy = 1'b0; rx_busy = 1'b0; rx_failed = 1'b0;
  endtask

  task automatic do_reset_release();
    clk_reset_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    clk_reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_state(input logic [3:0] s, input int limit, output bit ok);
    int n;
    n = 0;
    while (state !== s && n < limit) begin
      tick();
      n++;
    end
    ok = (state === s);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL wait_state: state=%0d, expected %0d within %0d cycles", state, s, limit);
    end
  endtask

  // Plays one send/receive round; tx_at/rx_at count cycles from the first SEND cycle.
  task automatic run_round(input int tx_at, input int rx_at, input logic [3:0] exp_round);
    bit ok;
    wait_state(4'd3, 300, ok);
    if (ok) begin
      for (int k = 0; k <= rx_at; k++) begin
        if (k == tx_at) tx_done = 1'b1;
        if (k == rx_at) begin
          rx_done = 1'b1;
          tx_busy = 1'b0;
          rx_busy = 1'b0;
          exp_lat.push_back(rx_at + 1);
        end else begin
          tick();
        end
      end
      tick();
      tx_done = 1'b0;
      rx_done = 1'b0;
      checks++;
      if (round_cnt !== exp_round) begin
        errors++;
        $display("[TB] FAIL round_cnt: got %0d, expected %0d", round_cnt, exp_round);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    int pm_seen;
    clk_reset_n = 1'b0;
    clear_inputs();
    tick();
    checks++;
    if (sys_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_sys_reset: got %b, expected 1", sys_reset); end
    checks++;
    if (state !== 4'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d, expected 0", state); end
    checks++;
    if ({test_done, test_pass, fail_code} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_status: done/pass/code=%b, expected 00000", {test_done, test_pass, fail_code});
    end
    checks++;
    if ({lbus_tx_rx_restart_in, s_axi_pm_tick, round_cnt, latency_cycles, latency_valid} !== 23'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h, expected 0",
                         {lbus_tx_rx_restart_in, s_axi_pm_tick, round_cnt, latency_cycles, latency_valid});
    end
    tick();
    clk_reset_n = 1'b1;
    cyc = 0;
    n = 0;
    pm_seen = 0;
    while (sys_reset === 1'b1 && n < 100) begin
      tick();
      n++;
      if (s_axi_pm_tick === 1'b1 && sys_reset === 1'b1) pm_seen++;
    end
    checks++;
    if (n !== 16) begin errors++; $display("[TB] FAIL sys_reset_length: high %0d cycles, expected 16", n); end
    checks++;
    if (state !== 4'd1) begin errors++; $display("[TB] FAIL state_after_hold: got %0d, expected 1", state); end
    checks++;
    if (pm_seen !== 0) begin errors++; $display("[TB] FAIL pm_during_reset: %0d ticks, expected 0", pm_seen); end
  endtask

  task automatic test_nominal_run();
    bit ok;
    int lat0, rs0;
    lat0 = lat_pulses;
    rs0  = restart_pulses;
    wait_until(50); rx_gt_locked = 1'b1;
    wait_until(80); rx_aligned = 1'b1;
    run_round(10, 30, 4'd1);
    wait_state(4'd7, 20, ok);
    tx_busy = 1'b1;
    rx_busy = 1'b1;
    run_round(10, 30, 4'd2);
    wait_state(4'd9, 20, ok);
    repeat (5) tick();
    checks++;
    if (state !== 4'd9) begin errors++; $display("[TB] FAIL done_terminal: state=%0d, expected 9", state); end
    checks++;
    if ({test_done, test_pass, fail_code} !== 5'b11000) begin
      errors++; $display("[TB] FAIL done_status: done/pass/code=%b, expected 11000", {test_done, test_pass, fail_code});
    end
    checks++;
    if (round_cnt !== 4'd2) begin errors++; $display("[TB] FAIL final_rounds: got %0d, expected 2", round_cnt); end
    checks++;
    if (restart_pulses - rs0 !== 1) begin
      errors++; $display("[TB] FAIL restart_count: got %0d, expected 1", restart_pulses - rs0);
    end
    checks++;
    if (lat_pulses - lat0 !== 2) begin
      errors++; $display("[TB] FAIL latency_pulse_count: got %0d, expected 2", lat_pulses - lat0);
    end
    checks++;
    if (exp_lat.size() !== 0) begin
      errors++; $display("[TB] FAIL scoreboard_drained: %0d entries left, expected 0", exp_lat.size());
    end
    checks++;
    if (latency_cycles !== 16'd31) begin errors++; $display("[TB] FAIL latency_held: got %0d, expected 31", latency_cycles); end
  endtask

  task automatic test_align_timeout();
    bit ok;
    int n;
    do_reset_release();
    rx_gt_locked = 1'b1;
    wait_state(4'd2, 100, ok);
    n = 0;
    while (state === 4'd2 && n < 400) begin
      n++;
      tick();
    end
    checks++;
    if (n < 255 || n > 256) begin
      errors++; $display("[TB] FAIL align_timeout_length: %0d cycles in state 2, expected 255..256", n);
    end
    checks++;
    if (state !== 4'd10) begin errors++; $display("[TB] FAIL align_timeout_state: got %0d, expected 10", state); end
    checks++;
    if ({test_done, test_pass, fail_code} !== 5'b10010) begin
      errors++; $display("[TB] FAIL align_timeout_status: done/pass/code=%b, expected 10010", {test_done, test_pass, fail_code});
    end
    rx_aligned = 1'b1;
    repeat (20) tick();
    checks++;
    if ({state, fail_code} !== {4'd10, 3'd2}) begin
      errors++; $display("[TB] FAIL fail_terminal: state/code=%0d/%0d, expected 10/2", state, fail_code);
    end
  endtask

  task automatic test_rx_failed();
    bit ok;
    int lat0;
    do_reset_release();
    rx_gt_locked = 1'b1;
    rx_aligned   = 1'b1;
    wait_state(4'd3, 100, ok);
    lat0 = lat_pulses;
    repeat (10) tick();
    tx_done = 1'b1;
    repeat (20) tick();
    rx_done   = 1'b1;
    rx_failed = 1'b1;
    tick();
    rx_failed = 1'b0;
    checks++;
    if ({state, fail_code} !== {4'd10, 3'd6}) begin
      errors++; $display("[TB] FAIL rx_failed_state: state/code=%0d/%0d, expected 10/6", state, fail_code);
    end
    checks++;
    if ({round_cnt, latency_cycles} !== 20'd0) begin
      errors++; $display("[TB] FAIL rx_failed_no_capture: rounds=%0d latency=%0d, expected 0/0", round_cnt, latency_cycles);
    end
    repeat (3) tick();
    checks++;
    if (lat_pulses - lat0 !== 0) begin
      errors++; $display("[TB] FAIL rx_failed_valid: %0d latency_valid pulses, expected 0", lat_pulses - lat0);
    end
    checks++;
    if ({test_done, test_pass} !== 2'b10) begin
      errors++; $display("[TB] FAIL rx_failed_status: done/pass=%b, expected 10", {test_done, test_pass});
    end
  endtask

  task automatic test_pm_tick();
    int t1, t2, t3, n;
    do_reset_release();
    n = 0;
    while (s_axi_pm_tick !== 1'b1 && n < 300) begin tick(); n++; end
    t1 = cyc;
    tick();
    checks++;
    if (s_axi_pm_tick !== 1'b0) begin errors++; $display("[TB] FAIL pm_width: tick high 2 cycles, expected 1"); end
    n = 0;
    while (s_axi_pm_tick !== 1'b1 && n < 300) begin tick(); n++; end
    t2 = cyc;
    tick();
    n = 0;
    while (s_axi_pm_tick !== 1'b1 && n < 300) begin tick(); n++; end
    t3 = cyc;
    checks++;
    if (t2 - t1 !== 100) begin errors++; $display("[TB] FAIL pm_period_1: spacing %0d, expected 100", t2 - t1); end
    checks++;
    if (t3 - t2 !== 100) begin errors++; $display("[TB] FAIL pm_period_2: spacing %0d, expected 100", t3 - t2); end
  endtask

  task automatic test_restart_cut();
    do_reset_release();
    rx_gt_locked = 1'b1;
    rx_aligned   = 1'b1;
    run_round(5, 12, 4'd1);
    tick();
    checks++;
    if ({state, lbus_tx_rx_restart_in} !== {4'd6, 1'b1}) begin
      errors++; $display("[TB] FAIL restart_pulse: state/restart=%0d/%b, expected 6/1", state, lbus_tx_rx_restart_in);
    end
    #2 clk_reset_n = 1'b0;
    #1;
    checks++;
    if ({lbus_tx_rx_restart_in, state, sys_reset, round_cnt} !== {1'b0, 4'd0, 1'b1, 4'd0}) begin
      errors++; $display("[TB] FAIL restart_cut: restart/state/sys_reset/rounds=%b/%0d/%b/%0d, expected 0/0/1/0",
                         lbus_tx_rx_restart_in, state, sys_reset, round_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    do_reset_release();
    rx_gt_locked = 1'b1;
    rx_aligned   = 1'b1;
    run_round(10, 30, 4'd1);
    wait_state(4'd7, 20, ok);
    tx_busy = 1'b1;
    rx_busy = 1'b1;
    wait_state(4'd3, 20, ok);
    repeat (5) tick();
    #2 clk_reset_n = 1'b0;
    #1;
    checks++;
    if ({sys_reset, lbus_tx_rx_restart_in, s_axi_pm_tick, state, round_cnt, latency_cycles,
         latency_valid, test_done, test_pass, fail_code} !== {1'b1, 32'b0}) begin
      errors++; $display("[TB] FAIL reset_mid_send: outputs=%h, expected %h",
                         {sys_reset, lbus_tx_rx_restart_in, s_axi_pm_tick, state, round_cnt, latency_cycles,
                          latency_valid, test_done, test_pass, fail_code}, {1'b1, 32'b0});
    end
    tick();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_nominal_run();
    test_align_timeout();
    test_rx_failed();
    test_pm_tick();
    test_restart_cut();
    test_reset_mid_send();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
